// File: rtl/logic_unit_chunked.sv
// rtl/logic_unit_chunked.sv - multi-cycle bitwise logic unit processing WIDTH-bit operands CHUNK bits per clock
//
// Purpose:
//   Evaluates AND / XOR / NOT A / OR on a WIDTH-bit operand pair by sweeping a
//   CHUNK-bit slice per clock through one shared gate array, then reports zero
//   and sign flags for the condition-code logic. Both sides use valid/ready.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation request valid
//   in_ready   unit idle and able to accept an operation
//   op         00 AND, 01 XOR, 10 NOT A (b ignored), 11 OR
//   a, b       WIDTH-bit operands
//   out_valid  result and flags valid
//   out_ready  consumer accepts the result
//   result     registered WIDTH-bit result
//   zf         result == 0
//   sf         result[WIDTH-1]
module logic_unit_chunked #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             sf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic [CW-1:0]    cnt;
  logic             nz_acc;
  logic [CHUNK-1:0] a_s;
  logic [CHUNK-1:0] b_s;
  logic [CHUNK-1:0] slice;
  logic             accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)     state_next = BUSY;
      BUSY:    if (cnt == LAST)  state_next = DONE;
      DONE:    if (out_ready)    state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  // Select the current slice of the captured operands.
  always_comb begin
    a_s = '0;
    b_s = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (cnt == CW'(k)) begin
        a_s = a_q[k*CHUNK +: CHUNK];
        b_s = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  // Shared gate array. The NOT branch never reads b_s, so an unknown b
  // cannot leak into the result.
  always_comb begin
    case (op_q)
      2'b00:   slice = a_s & b_s;
      2'b01:   slice = a_s ^ b_s;
      2'b10:   slice = ~a_s;
      default: slice = a_s | b_s;
    endcase
  end

  // Operand capture, slice write-back and flag generation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= 2'b00;
      cnt    <= '0;
      nz_acc <= 1'b0;
      result <= '0;
      zf     <= 1'b0;
      sf     <= 1'b0;
    end else if (accept) begin
      a_q    <= a;
      b_q    <= b;
      op_q   <= op;
      cnt    <= '0;
      nz_acc <= 1'b0;
    end else if (state == BUSY) begin
      for (int k = 0; k < NCHUNK; k++) begin
        if (cnt == CW'(k)) begin
          result[k*CHUNK +: CHUNK] <= slice;
        end
      end
      nz_acc <= nz_acc | (|slice);
      if (cnt == LAST) begin
        // The final slice is still in flight, so fold it in directly; the
        // top slice also carries the result MSB.
        zf <= ~(nz_acc | (|slice));
        sf <= slice[CHUNK-1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_chunked.sv
// tb/tb_logic_unit_chunked.sv - self-checking bench for logic_unit_chunked at CHUNK = 16, 64 and 8
module tb_logic_unit_chunked;

  localparam int W = 64;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid  [3];
  logic           in_ready  [3];
  logic [1:0]     op        [3];
  logic [W-1:0]   a         [3];
  logic [W-1:0]   b         [3];
  logic           out_valid [3];
  logic           out_ready [3];
  logic [W-1:0]   result    [3];
  logic           zf        [3];
  logic           sf        [3];

  int asserts = 0;
  int fails   = 0;
  int cyc_cnt = 0;

  typedef struct {
    logic [W-1:0] r;
    logic         zf;
    logic         sf;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Instance 0: CHUNK=16, instance 1: CHUNK=64, instance 2: CHUNK=8
  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic_unit_chunked #(
      .WIDTH(W),
      .CHUNK(g == 0 ? 16 : (g == 1 ? 64 : 8))
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .op        (op[g]),
      .a         (a[g]),
      .b         (b[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .result    (result[g]),
      .zf        (zf[g]),
      .sf        (sf[g])
    );
  end

  function automatic int nch(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 1 : 8);
  endfunction

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x ^ y;
      2'b10:   return ~x;
      default: return x | y;
    endcase
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      asserts++;
      if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || result[d] !== '0 || zf[d] !== 1'b0 || sf[d] !== 1'b0) begin
        fails++;
        $display("FAIL reset[%0d]: in_ready=%b out_valid=%b result=%h zf=%b sf=%b, required 1 0 0 0 0",
                 d, in_ready[d], out_valid[d], result[d], zf[d], sf[d]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One operation through instance d with out_ready held low for 'stall' cycles after out_valid.
  task automatic run_op(input int d, input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic [W-1:0] exp_r, input int stall, input string nm);
    exp_t e;
    int   w;
    int   lat;
    e.r  = exp_r;
    e.zf = (exp_r == '0);
    e.sf = exp_r[W-1];
    sb.push_back(e);
    @(negedge clk);
    op[d] = o; a[d] = aa; b[d] = bb; in_valid[d] = 1'b1; out_ready[d] = 1'b0;
    w = 0;
    while (in_ready[d] !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    asserts++;
    if (w >= 50) begin
      fails++;
      $display("FAIL %s accept[%0d]: in_ready=%b, required 1", nm, d, in_ready[d]);
      in_valid[d] = 1'b0;
      void'(sb.pop_back());
      return;
    end
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    b[d] = '0;
    asserts++;
    if (in_ready[d] !== 1'b0) begin
      fails++;
      $display("FAIL %s busy_ready[%0d]: in_ready=%b, required 0", nm, d, in_ready[d]);
    end
    lat = 0;
    while (out_valid[d] !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    asserts++;
    if (lat != nch(d)) begin
      fails++;
      $display("FAIL %s latency[%0d]: %0d cycles, required %0d", nm, d, lat, nch(d));
    end
    e = sb.pop_front();
    for (int s = 0; s <= stall; s++) begin
      asserts++;
      if (result[d] !== e.r || zf[d] !== e.zf || sf[d] !== e.sf) begin
        fails++;
        $display("FAIL %s data[%0d] cycle %0d: result=%h zf=%b sf=%b, required %h %b %b",
                 nm, d, s, result[d], zf[d], sf[d], e.r, e.zf, e.sf);
      end
      asserts++;
      if (out_valid[d] !== 1'b1 || in_ready[d] !== 1'b0 || $isunknown({result[d], zf[d], sf[d]})) begin
        fails++;
        $display("FAIL %s hold[%0d] cycle %0d: out_valid=%b in_ready=%b, required 1 0 and no X",
                 nm, d, s, out_valid[d], in_ready[d]);
      end
      if (s < stall) begin
        @(posedge clk);
        #1;
      end
    end
    out_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[d] = 1'b0;
    asserts++;
    if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0) begin
      fails++;
      $display("FAIL %s release[%0d]: in_ready=%b out_valid=%b, required 1 0", nm, d, in_ready[d], out_valid[d]);
    end
  endtask

  task automatic test_basic(input int d);
    run_op(d, 2'b00, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0F0F_0000_0F0F_0000, 0, "and");
    run_op(d, 2'b01, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'h0, 0, "xor_zero");
    run_op(d, 2'b10, 64'h0, 64'hx, 64'hFFFF_FFFF_FFFF_FFFF, 0, "not_bx");
    run_op(d, 2'b11, 64'h8000_0000_0000_0000, 64'h1, 64'h8000_0000_0000_0001, 5, "or_stall");
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    op[0] = 2'b00; a[0] = 64'hFFFF_0000_FFFF_0000; b[0] = 64'h0F0F_0F0F_0F0F_0F0F;
    in_valid[0] = 1'b1; out_ready[0] = 1'b0;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    asserts++;
    if (in_ready[0] !== 1'b0 || result[0] === '0) begin
      fails++;
      $display("FAIL mid_reset_pre: in_ready=%b result=%h, required 0 and partial nonzero", in_ready[0], result[0]);
    end
    rst_n = 1'b0;
    #1;
    asserts++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || result[0] !== '0 || zf[0] !== 1'b0 || sf[0] !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_async: in_ready=%b out_valid=%b result=%h zf=%b sf=%b, required 1 0 0 0 0",
               in_ready[0], out_valid[0], result[0], zf[0], sf[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 2'b00, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0F0F_0000_0F0F_0000, 0, "and_after_reset");
  endtask

  // in_valid held high and out_ready tied high: the unit spends NCHUNK
  // cycles in BUSY and one in DONE between accepts, so accept edges are
  // NCHUNK+2 clocks apart.
  task automatic test_back_to_back(input int d, input int n);
    int got;
    int t_prev;
    out_ready[d] = 1'b1;
    got = 0;
    t_prev = 0;
    @(negedge clk);
    fork
      begin : driver
        logic [1:0]   o;
        logic [W-1:0] aa;
        logic [W-1:0] bb;
        exp_t         e;
        int           w;
        int           t;
        for (int i = 0; i < n; i++) begin
          o  = 2'($urandom_range(0, 3));
          aa = {$urandom, $urandom};
          bb = {$urandom, $urandom};
          e.r  = model(o, aa, bb);
          e.zf = (e.r == '0);
          e.sf = e.r[W-1];
          sb.push_back(e);
          op[d] = o; a[d] = aa; b[d] = bb; in_valid[d] = 1'b1;
          w = 0;
          while (in_ready[d] !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
          end
          if (w >= 50) begin
            asserts++;
            fails++;
            $display("FAIL b2b_accept[%0d] op %0d: in_ready=%b, required 1", d, i, in_ready[d]);
            break;
          end
          @(posedge clk);
          #1;
          t = cyc_cnt;
          if (i > 0) begin
            asserts++;
            if (t - t_prev != nch(d) + 2) begin
              fails++;
              $display("FAIL b2b_interval[%0d] op %0d: %0d cycles, required %0d", d, i, t - t_prev, nch(d) + 2);
            end
          end
          t_prev = t;
          @(negedge clk);
        end
        in_valid[d] = 1'b0;
      end
      begin : monitor
        exp_t e;
        int   c;
        c = 0;
        while (got < n && c < n * (nch(d) + 2) + 50) begin
          @(negedge clk);
          c++;
          if (out_valid[d] === 1'b1) begin
            asserts++;
            if (sb.size() == 0) begin
              fails++;
              $display("FAIL b2b_extra[%0d]: result=%h with empty scoreboard, required no output", d, result[d]);
            end else begin
              e = sb.pop_front();
              if (result[d] !== e.r || zf[d] !== e.zf || sf[d] !== e.sf) begin
                fails++;
                $display("FAIL b2b_data[%0d] op %0d: result=%h zf=%b sf=%b, required %h %b %b",
                         d, got, result[d], zf[d], sf[d], e.r, e.zf, e.sf);
              end
            end
            got++;
          end
        end
      end
    join
    asserts++;
    if (got != n || sb.size() != 0) begin
      fails++;
      $display("FAIL b2b_count[%0d]: %0d results, %0d pending, required %0d and 0", d, got, sb.size(), n);
    end
    sb.delete();
    out_ready[d] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      op[d]        = 2'b00;
      a[d]         = '0;
      b[d]         = '0;
      out_ready[d] = 1'b0;
    end
    test_reset();
    for (int d = 0; d < 3; d++) test_basic(d);
    test_mid_reset();
    for (int d = 0; d < 3; d++) test_back_to_back(d, 100);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
